// File: rtl/gcd_job_dispatcher.sv
// Operand FIFO plus single-job issue FSM feeding a GCD engine.
// Results land in a valid/ready register; a watchdog drops hung jobs.
module gcd_job_dispatcher #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [WIDTH-1:0]         in_a_i,
    input  logic [WIDTH-1:0]         in_b_i,
    output logic [WIDTH-1:0]         op_a_o,
    output logic [WIDTH-1:0]         op_b_o,
    output logic                     req_o,
    input  logic                     busy_i,
    input  logic                     valid_i,
    input  logic [WIDTH-1:0]         result_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [WIDTH-1:0]         out_result_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     timeout_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]        level_q, level_d;
    logic [WIDTH-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 out_valid_q, out_valid_d;
    logic                 timeout_q, timeout_d;
    logic [CW-1:0]        wd_q, wd_d;
    logic [2*WIDTH-1:0]   mem_q [DEPTH];
    logic [2*WIDTH-1:0]   head;
    logic                 push, pop;

    assign in_ready_o   = level_q < LW'(DEPTH);
    assign push         = in_valid_i && in_ready_o;
    assign pop          = (state_q == IDLE) && (level_q != '0)
                          && !busy_i && !out_valid_q;
    assign head         = mem_q[rd_ptr_q];
    assign level_d      = level_q + LW'(push) - LW'(pop);

    assign req_o        = state_q == ISSUE;
    assign op_a_o       = op_a_q;
    assign op_b_o       = op_b_q;
    assign out_valid_o  = out_valid_q;
    assign out_result_o = res_q;
    assign level_o      = level_q;
    assign timeout_o    = timeout_q;

    // Storage needs no reset; only the pointers/level define validity.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {in_a_i, in_b_i};
    end

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_d       = res_q;
        wd_d        = wd_q;
        timeout_d   = timeout_q;
        out_valid_d = out_valid_q && !out_ready_i;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    op_a_d  = head[2*WIDTH-1:WIDTH];
                    op_b_d  = head[WIDTH-1:0];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (valid_i) begin
                    res_d       = result_i;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end else if (wd_q == CW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            timeout_q   <= timeout_d;
            wd_q        <= wd_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

endmodule

// File: tb/tb_gcd_job_dispatcher.sv
// Randomized + directed bench for gcd_job_dispatcher.
// Reference: queue of pending pairs, Euclid-based expected results.
module tb_gcd_job_dispatcher;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic [3:0] in_a_i = '0, in_b_i = '0;
    logic [3:0] op_a_o, op_b_o;
    logic       req_o;
    logic       busy_i = 1'b0;
    logic       valid_i = 1'b0;
    logic [3:0] result_i = '0;
    logic       out_valid_o;
    logic       out_ready_i = 1'b0;
    logic [3:0] out_result_o;
    logic [2:0] level_o;
    logic       timeout_o;

    gcd_job_dispatcher #(.WIDTH(4), .DEPTH(4), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_a_i(in_a_i), .in_b_i(in_b_i),
        .op_a_o(op_a_o), .op_b_o(op_b_o), .req_o(req_o),
        .busy_i(busy_i), .valid_i(valid_i), .result_i(result_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_result_o(out_result_o), .level_o(level_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;
    logic [7:0] mfifo[$];
    int exp_res[$];
    int got_res[$];
    bit d_rst = 1'b1, d_valid = 1'b0, d_ready = 1'b0;
    logic [3:0] d_a = '0, d_b = '0;
    bit hang = 1'b0, force_busy = 1'b0, eng_busy = 1'b0, pushed = 1'b0;
    int lat = 3, eng_cnt = 0, eng_res = 0;

    task automatic check(string tag, int got, int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int gcd(int a, int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic cycle();
        logic [7:0] pr;
        @(negedge clk);
        if (!rst_i) begin
            if (req_o) begin
                if (mfifo.size() == 0) check("req_on_empty", 1, 0);
                else begin
                    pr = mfifo.pop_front();
                    check("op_a", op_a_o, pr[7:4]);
                    check("op_b", op_b_o, pr[3:0]);
                    eng_res = gcd(pr[7:4], pr[3:0]);
                    if (!hang) exp_res.push_back(eng_res);
                end
            end
            check("level", level_o, mfifo.size());
            check("in_ready", in_ready_o, mfifo.size() < 4);
        end
        if (valid_i) begin
            valid_i  = 1'b0;
            result_i = '0;
            eng_busy = 1'b0;
        end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                valid_i  = 1'b1;
                result_i = 4'(eng_res);
            end
        end
        if (req_o && !rst_i && !hang) begin
            eng_busy = 1'b1;
            eng_cnt  = lat;
        end
        rst_i       = d_rst;
        in_valid_i  = d_valid;
        in_a_i      = d_a;
        in_b_i      = d_b;
        out_ready_i = d_ready;
        pushed      = 1'b0;
        if (d_rst) begin
            mfifo.delete();
            exp_res.delete();
            eng_busy = 1'b0;
            eng_cnt  = 0;
            valid_i  = 1'b0;
        end else begin
            if (in_valid_i && in_ready_o) begin
                mfifo.push_back({d_a, d_b});
                pushed = 1'b1;
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_res.size() == 0) check("unexpected_out", 1, 0);
                else check("out_result", out_result_o, exp_res.pop_front());
                got_res.push_back(int'(out_result_o));
            end
        end
        busy_i = eng_busy || force_busy;
    endtask

    task automatic push_one(logic [3:0] a, logic [3:0] b);
        d_valid = 1'b1;
        d_a = a;
        d_b = b;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (pushed) break;
        end
        if (!pushed) check("push_timeout", 0, 1);
        d_valid = 1'b0;
    endtask

    task automatic wait_req(string tag);
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (req_o) break;
        end
        check(tag, req_o, 1);
    endtask

    task automatic wait_out(string tag);
        for (int i = 0; i < 30; i++) begin
            if (out_valid_o) break;
            cycle();
        end
        check(tag, out_valid_o, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got 0 exp 1");
        $fatal(1, "bench hung");
    end

    initial begin
        logic [3:0] fa[5];
        logic [3:0] fb[5];
        int exp5[5];
        fa = '{4'd12, 4'd9, 4'd15, 4'd7, 4'd14};
        fb = '{4'd8, 4'd6, 4'd10, 4'd3, 4'd4};
        exp5 = '{4, 3, 5, 1, 2};

        repeat (3) cycle();
        d_rst = 1'b0;
        cycle();
        check("rst_level", level_o, 0);
        check("rst_in_ready", in_ready_o, 1);
        check("rst_req", req_o, 0);
        check("rst_op_a", op_a_o, 0);
        check("rst_op_b", op_b_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_result", out_result_o, 0);
        check("rst_timeout", timeout_o, 0);

        // single job, latency 3
        d_ready = 1'b1;
        lat = 3;
        d_valid = 1'b1; d_a = 12; d_b = 8;
        cycle();
        d_valid = 1'b0;
        cycle();
        check("single_req_t1", req_o, 0);
        cycle();
        check("single_req_t2", req_o, 1);
        check("single_op_a", op_a_o, 12);
        check("single_op_b", op_b_o, 8);
        wait_out("single_out_valid");
        check("single_result", out_result_o, 4);
        repeat (3) cycle();

        // fill with engine busy, then backpressure, then ordered drain
        d_ready = 1'b0;
        force_busy = 1'b1;
        cycle();
        got_res.delete();
        for (int i = 0; i < 4; i++) push_one(fa[i], fb[i]);
        d_valid = 1'b1; d_a = fa[4]; d_b = fb[4];
        repeat (3) begin
            cycle();
            check("fill_held", pushed, 0);
            check("busy_no_req", req_o, 0);
        end
        check("full_level", level_o, 4);
        check("full_in_ready", in_ready_o, 0);
        force_busy = 1'b0;
        cycle();
        check("busy_rel_req0", req_o, 0);
        cycle();
        check("busy_rel_req1", req_o, 1);
        check("fifth_pushed", pushed, 1);
        d_valid = 1'b0;
        wait_out("bp_out_valid");
        repeat (6) begin
            cycle();
            check("bp_no_req", req_o, 0);
            check("bp_hold_valid", out_valid_o, 1);
            check("bp_hold_result", out_result_o, 4);
        end
        d_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (got_res.size() >= 5) break;
            cycle();
        end
        check("drain_count", got_res.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < got_res.size()) check("drain_order", got_res[i], exp5[i]);

        // watchdog: engine never answers
        hang = 1'b1;
        push_one(10, 5);
        wait_req("wd_req");
        repeat (8) cycle();
        check("wd_not_yet", timeout_o, 0);
        cycle();
        check("wd_timeout", timeout_o, 1);
        check("wd_out_valid", out_valid_o, 0);
        hang = 1'b0;
        push_one(6, 4);
        wait_req("wd_next_req");
        wait_out("wd_next_out");
        check("wd_next_result", out_result_o, 2);
        check("wd_sticky", timeout_o, 1);
        repeat (3) cycle();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            d_valid = 1'($urandom_range(0, 1));
            d_a = 4'($urandom);
            d_b = 4'($urandom);
            if ($urandom_range(0, 7) == 0) d_b = 0;
            d_ready = $urandom_range(0, 3) != 0;
            lat = $urandom_range(1, 5);
            cycle();
        end
        d_valid = 1'b0;
        d_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (mfifo.size() == 0 && exp_res.size() == 0 && !out_valid_o
                && !eng_busy) break;
            cycle();
        end
        check("rand_fifo_empty", mfifo.size(), 0);
        check("rand_res_empty", exp_res.size(), 0);

        // reset during WAIT, late engine result ignored
        lat = 5;
        push_one(9, 3);
        wait_req("rw_req");
        cycle();
        d_rst = 1'b1;
        cycle();
        d_rst = 1'b0;
        cycle();
        valid_i = 1'b1;
        result_i = 6;
        cycle();
        cycle();
        check("rw_out_valid", out_valid_o, 0);
        check("rw_level", level_o, 0);
        check("rw_req", req_o, 0);
        check("rw_timeout", timeout_o, 0);
        check("rw_out_result", out_result_o, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
